// File: rtl/seven_seg_pkg.sv
// Shared types and constants for the seven-segment display path.
package seven_seg_pkg;

    localparam int unsigned BCD_W   = 4;
    localparam int unsigned BCD_MAX = 9;

    typedef logic [BCD_W-1:0] bcd_t;

    typedef enum logic {
        BLANK = 1'b0,
        DRIVE = 1'b1
    } scan_state_t;

    // True when the nibble is a legal decimal digit.
    function automatic logic is_bcd(input bcd_t d);
        return (d <= bcd_t'(BCD_MAX));
    endfunction

endpackage

// File: rtl/bcd_digit_scanner.sv
// Multi-digit BCD scanner: loads a value over valid/ready, commits it at frame
// boundaries, and time-multiplexes digits with a blanking gap before each one.
// Optional macro LEADING_ZERO_BLANK_EN darkens leading zero digits (digit 0 never).
// Outputs are registered from the current scan position, so they trail the
// internal state by one clock; frame_start therefore appears one clock after
// reset release.
module bcd_digit_scanner
    import seven_seg_pkg::*;
#(
    parameter int unsigned NUM_DIGITS   = 4,
    parameter int unsigned DWELL_CYCLES = 1000,
    parameter int unsigned BLANK_CYCLES = 8
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          load_valid,
    output logic                          load_ready,
    input  logic [BCD_W*NUM_DIGITS-1:0]   load_data,
    output logic [BCD_W-1:0]              bcd_out,
    output logic [NUM_DIGITS-1:0]         digit_en_n,
    output logic                          frame_start,
    output logic                          bcd_err
);

    localparam int unsigned MAX_CYC = (DWELL_CYCLES > BLANK_CYCLES) ? DWELL_CYCLES : BLANK_CYCLES;
    localparam int unsigned TW      = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
    localparam int unsigned IW      = $clog2(NUM_DIGITS);

`ifdef LEADING_ZERO_BLANK_EN
    // An all-zero display shows only digit 0.
    localparam logic [NUM_DIGITS-1:0] MASK_RST = {{(NUM_DIGITS-1){1'b1}}, 1'b0};
`else
    localparam logic [NUM_DIGITS-1:0] MASK_RST = '0;
`endif

    scan_state_t                 state, state_nxt;
    logic [IW-1:0]               idx, idx_nxt;
    logic [TW-1:0]               timer, timer_nxt;
    bcd_t [NUM_DIGITS-1:0]       display, display_nxt;
    bcd_t [NUM_DIGITS-1:0]       shadow, shadow_nxt;
    logic                        pending, pending_nxt;
    logic [NUM_DIGITS-1:0]       lzb_mask, lzb_mask_nxt;
    logic [NUM_DIGITS-1:0]       shadow_mask_c;
    logic [BCD_W-1:0]            bcd_out_nxt;
    logic [NUM_DIGITS-1:0]       digit_en_n_nxt;
    logic                        frame_start_nxt;
    logic                        bcd_err_nxt;
    logic                        load_ready_nxt;
    logic                        accept_c;
    logic                        commit_c;
    logic                        load_bad_c;
    bcd_t                        cur_c;
    bcd_t [NUM_DIGITS-1:0]       load_digits_c;

    assign load_digits_c = load_data;

    // Leading-zero mask of the value about to be committed.
    always_comb begin
        shadow_mask_c = '0;
`ifdef LEADING_ZERO_BLANK_EN
        begin
            logic zero_above;
            zero_above = 1'b1;
            for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
                zero_above       = zero_above && (shadow[i] == '0);
                shadow_mask_c[i] = zero_above;
            end
        end
`endif
    end

    // Flags any non-decimal nibble in the incoming load.
    always_comb begin
        load_bad_c = 1'b0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (!is_bcd(load_digits_c[i])) begin
                load_bad_c = 1'b1;
            end
        end
    end

    // Scan sequencing, handshake, commit and output decode.
    always_comb begin
        state_nxt       = state;
        idx_nxt         = idx;
        timer_nxt       = timer + TW'(1);
        display_nxt     = display;
        shadow_nxt      = shadow;
        pending_nxt     = pending;
        lzb_mask_nxt    = lzb_mask;
        bcd_err_nxt     = bcd_err;
        cur_c           = display[idx];
        bcd_out_nxt     = cur_c;
        digit_en_n_nxt  = '1;
        frame_start_nxt = 1'b0;

        accept_c = load_valid && load_ready;
        commit_c = (state == DRIVE) && (timer == TW'(DWELL_CYCLES - 1)) &&
                   (idx == IW'(NUM_DIGITS - 1)) && pending;

        case (state)
            BLANK: begin
                frame_start_nxt = (idx == '0) && (timer == '0);
                if (timer == TW'(BLANK_CYCLES - 1)) begin
                    state_nxt = DRIVE;
                    timer_nxt = '0;
                end
            end
            DRIVE: begin
                if (is_bcd(cur_c) && !lzb_mask[idx]) begin
                    digit_en_n_nxt[idx] = 1'b0;
                end
                if (timer == TW'(DWELL_CYCLES - 1)) begin
                    state_nxt = BLANK;
                    timer_nxt = '0;
                    idx_nxt   = (idx == IW'(NUM_DIGITS - 1)) ? '0 : idx + IW'(1);
                end
            end
            default: begin
                state_nxt = BLANK;
                timer_nxt = '0;
            end
        endcase

        if (commit_c) begin
            display_nxt  = shadow;
            lzb_mask_nxt = shadow_mask_c;
            pending_nxt  = 1'b0;
        end
        if (accept_c) begin
            shadow_nxt  = load_data;
            pending_nxt = 1'b1;
            bcd_err_nxt = bcd_err | load_bad_c;
        end

        load_ready_nxt = !pending_nxt;
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= BLANK;
            idx         <= '0;
            timer       <= '0;
            display     <= '0;
            shadow      <= '0;
            pending     <= 1'b0;
            lzb_mask    <= MASK_RST;
            bcd_out     <= '0;
            digit_en_n  <= '1;
            frame_start <= 1'b0;
            bcd_err     <= 1'b0;
            load_ready  <= 1'b1;
        end else begin
            state       <= state_nxt;
            idx         <= idx_nxt;
            timer       <= timer_nxt;
            display     <= display_nxt;
            shadow      <= shadow_nxt;
            pending     <= pending_nxt;
            lzb_mask    <= lzb_mask_nxt;
            bcd_out     <= bcd_out_nxt;
            digit_en_n  <= digit_en_n_nxt;
            frame_start <= frame_start_nxt;
            bcd_err     <= bcd_err_nxt;
            load_ready  <= load_ready_nxt;
        end
    end

endmodule

// File: tb/tb_bcd_digit_scanner.sv
// Directed bench for bcd_digit_scanner (4 digits, dwell 4, blank 2, 24-clock frame).
module tb_bcd_digit_scanner;

    localparam int unsigned ND    = 4;
    localparam int unsigned DWELL = 4;
    localparam int unsigned BLNK  = 2;
    localparam int unsigned SLOT  = DWELL + BLNK;
    localparam int unsigned FRAME = ND * SLOT;

    logic        clk;
    logic        rst_n;
    logic        load_valid;
    logic        load_ready;
    logic [15:0] load_data;
    logic [3:0]  bcd_out;
    logic [3:0]  digit_en_n;
    logic        frame_start;
    logic        bcd_err;

    int checks;
    int errors;
    int cyc;

    bcd_digit_scanner #(
        .NUM_DIGITS  (ND),
        .DWELL_CYCLES(DWELL),
        .BLANK_CYCLES(BLNK)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_valid (load_valid),
        .load_ready (load_ready),
        .load_data  (load_data),
        .bcd_out    (bcd_out),
        .digit_en_n (digit_en_n),
        .frame_start(frame_start),
        .bcd_err    (bcd_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int         cyc;
        logic       fs;
        logic [3:0] en;
        logic [3:0] bcd;
        logic       rdy;
    } vec_t;

    vec_t vecs[10];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d got=%0h expected=%0h", name, cyc, got, exp);
        end
    endtask

    // Advance to output cycle c (counted in negedges from the frame origin).
    task automatic goto(input int c);
        while (cyc < c) begin
            @(negedge clk);
            cyc++;
        end
    endtask

    // Digits that must stay dark while in DRIVE for a given display value.
    function automatic logic [3:0] dark_of(input logic [15:0] d);
        logic [3:0] m;
        logic [3:0] nib;
        logic       z;
        m = '0;
        for (int i = 0; i < 4; i++) begin
            nib = d[i*4 +: 4];
            if (nib > 4'd9) m[i] = 1'b1;
        end
        z = 1'b1;
`ifdef LEADING_ZERO_BLANK_EN
        for (int i = 3; i >= 1; i--) begin
            nib = d[i*4 +: 4];
            z   = z && (nib == 4'd0);
            if (z) m[i] = 1'b1;
        end
`endif
        if (!z) m = m;
        return m;
    endfunction

    // Compare every cycle in [from,to] against the expected scan of disp.
    task automatic span(input int from, input int to, input logic [15:0] disp);
        int         c;
        int         blk;
        int         pos;
        logic [3:0] dark;
        logic [3:0] exp_en;
        logic [3:0] exp_bcd;
        dark = dark_of(disp);
        for (int k = from; k <= to; k++) begin
            goto(k);
            c       = k % FRAME;
            blk     = c / SLOT;
            pos     = c % SLOT;
            exp_bcd = disp[blk*4 +: 4];
            if (pos < BLNK || dark[blk]) exp_en = 4'hF;
            else                         exp_en = 4'(~(4'b0001 << blk));
            check("digit_en_n", 32'(digit_en_n), 32'(exp_en));
            check("bcd_out", 32'(bcd_out), 32'(exp_bcd));
            check("frame_start", 32'(frame_start), 32'(c == 0));
        end
    endtask

    // Drive one load on the negedge before output cycle c (accepted at that edge).
    task automatic load_at(input int c, input logic [15:0] d);
        goto(c - 1);
        load_valid = 1'b1;
        load_data  = d;
        goto(c);
        load_valid = 1'b0;
    endtask

    initial begin
        logic [3:0] en_lz;
        checks     = 0;
        errors     = 0;
        cyc        = 0;
        rst_n      = 1'b0;
        load_valid = 1'b0;
        load_data  = '0;

`ifdef LEADING_ZERO_BLANK_EN
        en_lz = 4'hF;
`else
        en_lz = 4'h0;
`endif
        vecs[0] = '{0,  1'b1, 4'hF,                0, 1'b1};
        vecs[1] = '{1,  1'b0, 4'hF,                0, 1'b1};
        vecs[2] = '{2,  1'b0, 4'hE,                0, 1'b1};
        vecs[3] = '{5,  1'b0, 4'hE,                0, 1'b1};
        vecs[4] = '{6,  1'b0, 4'hF,                0, 1'b1};
        vecs[5] = '{8,  1'b0, 4'hD | en_lz,        0, 1'b1};
        vecs[6] = '{13, 1'b0, 4'hF,                0, 1'b1};
        vecs[7] = '{14, 1'b0, 4'hB | en_lz,        0, 1'b1};
        vecs[8] = '{20, 1'b0, 4'h7 | en_lz,        0, 1'b1};
        vecs[9] = '{23, 1'b0, 4'h7 | en_lz,        0, 1'b1};

        // Reset values while held in reset.
        repeat (3) @(negedge clk);
        check("rst bcd_out", 32'(bcd_out), 32'h0);
        check("rst digit_en_n", 32'(digit_en_n), 32'hF);
        check("rst load_ready", 32'(load_ready), 32'h1);
        check("rst frame_start", 32'(frame_start), 32'h0);
        check("rst bcd_err", 32'(bcd_err), 32'h0);

        // Release; the next negedge is output cycle 0.
        rst_n = 1'b1;
        @(negedge clk);
        cyc = 0;
        foreach (vecs[i]) begin
            goto(vecs[i].cyc);
            check("tbl frame_start", 32'(frame_start), 32'(vecs[i].fs));
            check("tbl digit_en_n", 32'(digit_en_n), 32'(vecs[i].en));
            check("tbl bcd_out", 32'(bcd_out), 32'(vecs[i].bcd));
            check("tbl load_ready", 32'(load_ready), 32'(vecs[i].rdy));
        end

        // Mid-frame load of 1234; a second load is held off while pending.
        load_at(30, 16'h1234);
        check("ready after load", 32'(load_ready), 32'h0);
        span(30, 38, 16'h0000);
        load_valid = 1'b1;
        load_data  = 16'h5678;
        span(39, 46, 16'h0000);
        check("ready while pending", 32'(load_ready), 32'h0);
        span(47, 47, 16'h0000);
        check("ready after commit", 32'(load_ready), 32'h1);
        span(48, 48, 16'h1234);
        load_valid = 1'b0;
        check("held load captured", 32'(load_ready), 32'h0);
        span(49, 71, 16'h1234);
        span(72, 94, 16'h5678);
        check("bcd_err clean", 32'(bcd_err), 32'h0);

        // Invalid nibble: error flag on acceptance, digit 2 dark once committed.
        load_at(96, 16'h9A09);
        check("bcd_err set", 32'(bcd_err), 32'h1);
        span(96, 119, 16'h5678);
        span(120, 142, 16'h9A09);

        // Reset mid-DRIVE with a load pending.
        load_at(144, 16'h1234);
        goto(147);
        #2 rst_n = 1'b0;
        #1;
        check("async bcd_out", 32'(bcd_out), 32'h0);
        check("async digit_en_n", 32'(digit_en_n), 32'hF);
        check("async load_ready", 32'(load_ready), 32'h1);
        check("async frame_start", 32'(frame_start), 32'h0);
        check("async bcd_err", 32'(bcd_err), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        cyc = 0;
        check("post-rst load_ready", 32'(load_ready), 32'h1);
        span(0, 46, 16'h0000);

        // Leading zeros (dark only when the optional blanking is built in).
        load_at(48, 16'h0050);
        span(48, 71, 16'h0000);
        span(72, 94, 16'h0050);
        load_at(96, 16'h0000);
        span(96, 119, 16'h0050);
        span(120, 143, 16'h0000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
